// File: rtl/vtarb_pkg.sv
// Shared definitions for the vtarb Wishbone arbiter: FSM encoding, park master
// and the width helper used to size the owner index and watchdog counter.
package vtarb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } state_t;

    localparam int PARK_MASTER = 0;

    function automatic int clog2(input int value);
        int w;
        w = 1;
        while ((1 << w) < value) w++;
        return w;
    endfunction

endpackage

// File: rtl/vtarb_if.sv
// Shared Wishbone bus between N masters, the arbiter and the slave decode.
// s_dat_i is a plain broadcast net: every master samples it directly.
interface vtarb_if #(
    parameter int N = 3
);
    logic [N-1:0]    m_cyc_i;
    logic [N-1:0]    m_stb_i;
    logic [N-1:0]    m_we_i;
    logic [16*N-1:0] m_adr_i;
    logic [16*N-1:0] m_dat_i;
    logic [2*N-1:0]  m_sel_i;
    logic [N-1:0]    m_gnt_o;
    logic [N-1:0]    m_ack_o;
    logic [N-1:0]    m_err_o;

    logic            s_cyc_o;
    logic            s_stb_o;
    logic            s_we_o;
    logic [15:0]     s_adr_o;
    logic [15:0]     s_dat_o;
    logic [1:0]      s_sel_o;
    logic            s_ack_i;
    logic [15:0]     s_dat_i;
    logic            tmo_o;

    // arbiter side
    modport master (
        input  m_cyc_i, m_stb_i, m_we_i, m_adr_i, m_dat_i, m_sel_i, s_ack_i,
        output m_gnt_o, m_ack_o, m_err_o,
        output s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o, tmo_o
    );

    // masters plus slave decode
    modport slave (
        output m_cyc_i, m_stb_i, m_we_i, m_adr_i, m_dat_i, m_sel_i, s_ack_i, s_dat_i,
        input  m_gnt_o, m_ack_o, m_err_o,
        input  s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o, tmo_o
    );

endinterface

// File: rtl/vtarb_rrsel.sv
// Round-robin picker over masters 1..N-1, starting after last_owner and
// wrapping; master 0 is handled by the FSM and never picked here.
module vtarb_rrsel
    import vtarb_pkg::*;
#(
    parameter int N  = 3,
    parameter int OW = clog2(N)
) (
    input  logic [N-1:1]  req,
    input  logic [OW-1:0] last_owner,
    output logic [N-1:0]  pick,
    output logic          valid
);

    int base;

    always_comb begin
        base  = int'(last_owner);
        pick  = '0;
        valid = 1'b0;
        for (int i = 1; i < N; i++) begin
            if (!valid && req[i] && (i > base)) begin
                pick[i] = 1'b1;
                valid   = 1'b1;
            end
        end
        for (int i = 1; i < N; i++) begin
            if (!valid && req[i] && (i <= base)) begin
                pick[i] = 1'b1;
                valid   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/vtarb.sv
// Wishbone arbiter parked on the CPU (master 0) with round-robin among the
// other masters and an ack watchdog that aborts hung transfers.
//   state | meaning
//   IDLE  | parked on master 0, s_* follows the CPU with no added latency
//   OWN   | bus locked to the granted master until it drops cyc
module vtarb
    import vtarb_pkg::*;
#(
    parameter int N   = 3,
    parameter int TMO = 255
) (
    input  logic    wb_clk_i,
    input  logic    wb_rst_n_i,
    vtarb_if.master bus
);

    localparam int             CW       = clog2(TMO);
    localparam int             OW       = clog2(N);
    localparam logic [N-1:0]   PARK_GNT = N'(1) << PARK_MASTER;
    localparam logic [CW-1:0]  CNT_LAST = CW'(TMO - 1);

    state_t        state;
    logic [N-1:0]  gnt_q;
    logic [N-1:0]  hold_q;
    logic [OW-1:0] last_owner;
    logic [CW-1:0] cnt;

    logic [N-1:0]  rr_pick;
    logic          rr_valid;
    logic [OW-1:0] pick_idx;
    logic          tmo_hit;
    logic          state_chg;

    logic          s_cyc;
    logic          s_stb;
    logic          s_we;
    logic [15:0]   s_adr;
    logic [15:0]   s_dat;
    logic [1:0]    s_sel;

    vtarb_rrsel #(
        .N  (N),
        .OW (OW)
    ) u_rrsel (
        .req        (bus.m_cyc_i[N-1:1]),
        .last_owner (last_owner),
        .pick       (rr_pick),
        .valid      (rr_valid)
    );

    // gnt_q is 001 in IDLE and one-hot(owner) in OWN, so one AND-OR mux covers both
    always_comb begin
        s_cyc = 1'b0;
        s_stb = 1'b0;
        s_we  = 1'b0;
        s_adr = '0;
        s_dat = '0;
        s_sel = '0;
        for (int i = 0; i < N; i++) begin
            s_cyc = s_cyc | (bus.m_cyc_i[i] & gnt_q[i]);
            s_stb = s_stb | (bus.m_stb_i[i] & gnt_q[i]);
            s_we  = s_we  | (bus.m_we_i[i]  & gnt_q[i]);
            s_adr = s_adr | (bus.m_adr_i[16*i +: 16] & {16{gnt_q[i]}});
            s_dat = s_dat | (bus.m_dat_i[16*i +: 16] & {16{gnt_q[i]}});
            s_sel = s_sel | (bus.m_sel_i[2*i +: 2]   & {2{gnt_q[i]}});
        end
    end

    always_comb begin
        pick_idx = '0;
        for (int i = 1; i < N; i++) begin
            if (rr_pick[i]) pick_idx = OW'(i);
        end
    end

    assign tmo_hit   = s_stb && !bus.s_ack_i && (cnt == CNT_LAST);
    assign state_chg = (state == IDLE) ?
                       (!tmo_hit && (bus.m_cyc_i[PARK_MASTER] || rr_valid)) :
                       (tmo_hit || !s_cyc);

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state      <= IDLE;
            gnt_q      <= PARK_GNT;
            last_owner <= '0;
            cnt        <= '0;
            hold_q     <= '0;
        end else begin
            // a timed-out master stays deaf to acks until it ends its cycle
            hold_q <= (hold_q | (gnt_q & {N{tmo_hit}})) & bus.m_cyc_i;

            if (state_chg || bus.s_ack_i || !s_stb || tmo_hit)
                cnt <= '0;
            else
                cnt <= cnt + CW'(1);

            case (state)
                IDLE: begin
                    if (!tmo_hit) begin
                        if (bus.m_cyc_i[PARK_MASTER]) begin
                            state <= OWN;
                            gnt_q <= PARK_GNT;
                        end else if (rr_valid) begin
                            state      <= OWN;
                            gnt_q      <= rr_pick;
                            last_owner <= pick_idx;
                        end
                    end
                end
                OWN: begin
                    if (tmo_hit || !s_cyc) begin
                        state <= IDLE;
                        gnt_q <= PARK_GNT;
                    end
                end
                default: begin
                    state <= IDLE;
                    gnt_q <= PARK_GNT;
                end
            endcase
        end
    end

    assign bus.m_gnt_o = gnt_q;
    assign bus.m_ack_o = gnt_q & bus.m_stb_i & ~hold_q & {N{bus.s_ack_i & wb_rst_n_i}};
    assign bus.m_err_o = gnt_q & {N{tmo_hit & wb_rst_n_i}};
    assign bus.tmo_o   = tmo_hit & wb_rst_n_i;
    assign bus.s_cyc_o = s_cyc;
    assign bus.s_stb_o = s_stb;
    assign bus.s_we_o  = s_we;
    assign bus.s_adr_o = s_adr;
    assign bus.s_dat_o = s_dat;
    assign bus.s_sel_o = s_sel;

endmodule

// File: doc/vtarb.md
VTARB -- requirements
Module: vtarb

Interface
REQ-001 SHALL have parameter N, default 3: number of Wishbone masters; master 0 is the CPU and is the park master.
REQ-002 SHALL have parameter TMO, default 255: number of ack-wait cycles before a bus timeout, legal range 2..65535.
REQ-003 SHALL have port wb_clk_i  in  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port wb_rst_n_i  in  1  reset; asynchronous, active-low.
REQ-005 SHALL have ports m_cyc_i, m_stb_i, m_we_i  in  N each  per-master Wishbone cycle, strobe and write enable.
REQ-006 SHALL have ports m_adr_i  in  16*N, m_dat_i  in  16*N, m_sel_i  in  2*N  per-master address, write data and byte selects.
REQ-007 SHALL have port m_gnt_o  out  N  per-master grant, one-hot or zero; bit 0 drives the CPU bus-grant input.
REQ-008 SHALL have ports m_ack_o, m_err_o  out  N each  per-master acknowledge and timeout error.
REQ-009 SHALL have ports s_cyc_o, s_stb_o, s_we_o  out  1, s_adr_o  out  16, s_dat_o  out  16, s_sel_o  out  2  to the slave decode.
REQ-010 SHALL have ports s_ack_i  in  1, s_dat_i  in  16  slave acknowledge and read data; s_dat_i is broadcast unchanged to all masters.
REQ-011 SHALL have port tmo_o  out  1  one-cycle pulse on a bus timeout.

Function
REQ-012 SHALL implement the states IDLE (parked on master 0) and OWN (bus held by register owner).
REQ-013 In IDLE: m_gnt_o = 1 (master 0 granted); s_* outputs mux master 0 combinationally, giving the CPU zero added latency.
REQ-014 IDLE -> OWN, owner=0: when m_cyc_i[0]=1; takes precedence over every other request in the same cycle.
REQ-015 IDLE -> OWN, owner=k: when m_cyc_i[0]=0 and another master requests; k = first requester after last_owner, in round-robin order 1..N-1 with wrap; gnt for k rises on the next cycle.
REQ-016 In OWN: m_gnt_o = one-hot(owner); s_* = owner inputs ANDed with its gnt; no preemption while m_cyc_i[owner]=1 (locked read-modify-write is preserved).
REQ-017 OWN -> IDLE: when m_cyc_i[owner]=0; last_owner updates only for owners 1..N-1; at least one IDLE cycle occurs between two non-CPU owners.
REQ-018 m_ack_o[i] = s_ack_i AND gnt[i] AND m_stb_i[i]; non-granted masters never see ack.
REQ-019 Watchdog counter: cleared on s_ack_i, on any state change, and while s_stb_o=0; increments while s_stb_o=1 and s_ack_i=0.
REQ-020 When the counter reaches TMO-1: pulse m_err_o[owner] and tmo_o for 1 cycle, force IDLE next cycle, clear the counter; a late ack after this point SHALL NOT be forwarded.
REQ-021 If s_ack_i and the timeout arrive in the same cycle, the ack wins: no error and no pulse.
REQ-022 If the owner drops m_cyc_i mid-transfer, the arbiter SHALL return to IDLE with no error.

Reset
REQ-023 Asserting wb_rst_n_i=0 at any time: state=IDLE, last_owner=0, counter=0, m_gnt_o=1, m_ack_o=0, m_err_o=0, tmo_o=0.
REQ-024 A reset asserted mid-transfer SHALL abandon that transfer without an ack or error pulse.

Structure
REQ-025 Shared package vtarb_pkg SHALL hold: the state encoding, the PARK_MASTER=0 constant, and the counter width function clog2(TMO).
REQ-026 One sub-module, vtarb_rrsel, SHALL hold the combinational round-robin picker (inputs req and last_owner, output one-hot pick plus valid); the FSM, watchdog and muxes stay in vtarb.

Verification
REQ-027 CPU read from IDLE, slave acks on cycle 2 -> no added latency, m_ack_o[0] on cycle 2, m_gnt_o stays 001.
REQ-028 Masters 1 and 2 request continuously, CPU idle -> grants alternate 010, IDLE, 100, IDLE, 010...
REQ-029 CPU and master 2 raise cyc in the same IDLE cycle -> CPU owns the bus; master 2 gets m_gnt_o=100 one cycle after CPU cyc falls.
REQ-030 Master 1 strobes, slave never acks, TMO=255 -> m_err_o[1] and tmo_o pulse exactly 255 cycles after stb; next cycle is IDLE with m_gnt_o=001.
REQ-031 Ack arrives on cycle TMO-1 -> m_ack_o[owner]=1, m_err_o=0, tmo_o=0.
REQ-032 wb_rst_n_i low mid-transfer of master 2 -> m_gnt_o=001 immediately; no ack or error on master 2.
